rule_dispatch: RTL and testbench
================================

RULE_DISPATCH -- requirements
Module: rule_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 8: maximum outstanding descriptors, a power of two from 2 to 64.
REQ-002 SHALL have parameter THREAD_NUM, default 4: number of CPU polling threads, from 1 to 256.
REQ-003 SHALL have these ports, clock and reset first:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  descriptor accepted when desc_valid and desc_ready are both high.
- desc_index  in  16  rule index.
- desc_md  in  32  packet metadata, carried through unchanged.
- lookup2rule_index_wr  out  1  rule read strobe.
- lookup2rule_index  out  16  rule read index.
- rule2lookup_data_wr  in  1  rule return valid.
- rule2lookup_data  in  32  returned rule.
- act_valid  out  1  result valid.
- act_ready  in  1  result consumed.
- act_discard  out  1  drop the packet.
- act_to_cpu  out  1  deliver to CPU.
- act_port_id  out  8  output port, or CPU thread id.
- act_md  out  32  metadata of the result.
- err_rule_ovf  out  1  sticky: a rule return arrived with no outstanding request.
- stat_discard_cnt  out  32  discard counter.
- stat_fwd_cnt  out  32  forwarded counter.

Function
REQ-004 SHALL register a descriptor accepted in cycle T: lookup2rule_index_wr is high for exactly one cycle at T+1, and lookup2rule_index equals desc_index.
REQ-005 SHALL push desc_md into a metadata FIFO of DEPTH entries in the accept cycle.
REQ-006 SHALL keep an outstanding count: +1 on each accept, -1 on each result handshake (act_valid and act_ready); both in one cycle leave it unchanged.
REQ-007 SHALL drive desc_ready = (outstanding < DEPTH), combinationally from registered state.
REQ-008 SHALL push every rule2lookup_data_wr beat into a rule FIFO of DEPTH entries; returns arrive in request order and are never backpressured.
REQ-009 SHALL ignore a rule return that arrives while the metadata FIFO holds no unmatched entry, and SHALL set err_rule_ovf, which stays set until reset.
REQ-010 SHALL load the output register when both FIFOs are non-empty and the output register is empty or handshaking in the same cycle; act_valid then rises in the following cycle.
REQ-011 SHALL decode the rule ctrl field, rule[31:28], with p = rule[7:0]:
- ctrl 0, and every value of 4 or above: discard=1, to_cpu=0, port=0.
- ctrl 1: to_cpu=1, port=p.
- ctrl 2: to_cpu=1, port = polling counter.
- ctrl 3: to_cpu=0, port=p.
REQ-012 SHALL advance the polling counter (8 bit) by one each time a ctrl-2 result is loaded into the output register, wrapping from THREAD_NUM-1 to 0.
REQ-013 SHALL hold act_valid, act_discard, act_to_cpu, act_port_id and act_md stable while act_valid is high and act_ready is low.
REQ-014 SHALL sustain one result per cycle when act_ready is held high.
REQ-015 SHALL NOT lose, duplicate or reorder results under any act_ready pattern.

Reset
REQ-016 SHALL, while rst is high, asynchronously clear to 0: both FIFOs, the outstanding count, the polling counter, err_rule_ovf, the stat counters, act_valid, the act_* fields and lookup2rule_index_wr.
REQ-017 SHALL drive desc_ready low while rst is high, and high in the first cycle after release.
REQ-018 SHALL discard all in-flight descriptors and results on a reset in mid-operation; rule returns that arrive after release for requests issued before reset are handled per REQ-009.

Configuration
REQ-019 SHALL use macro RULE_DISPATCH_STAT_EN.
- Defined: stat_discard_cnt increments on each result handshake with act_discard=1, and stat_fwd_cnt increments on each other result handshake; both saturate at 0xFFFFFFFF.
- Undefined: both ports are tied to 0, no counter logic is built, and all other behaviour is identical.

Verification
REQ-020 SHALL cover port forwarding: desc index 0x0005, md 0xA5A5_0001; return rule 0x3000_0007 -> act_port_id=7, to_cpu=0, discard=0, md=0xA5A5_0001.
REQ-021 SHALL cover polling: 6 descriptors, all returning rule 0x2000_0000, THREAD_NUM=4 -> act_port_id sequence 0,1,2,3,0,1.
REQ-022 SHALL cover backpressure: act_ready low and 8 descriptors offered -> desc_ready low after the 8th accept, lookup2rule_index_wr count is 8; act_ready then high -> 8 results in order, desc_ready high again.
REQ-023 SHALL cover decode: rules 0x0000_0003, 0x1000_0009, 0xF000_0002 -> discard; to_cpu with port 9; discard.
REQ-024 SHALL cover error and reset: a rule return with nothing outstanding -> err_rule_ovf=1; rst pulsed mid-stream with 3 outstanding -> all outputs 0, desc_ready=1 one cycle after release.
REQ-025 SHALL cover counters: with RULE_DISPATCH_STAT_EN defined, 3 discards and 5 forwards -> stat_discard_cnt=3, stat_fwd_cnt=5; without the macro, both read 0.

Source files
------------

// File: rtl/rule_dispatch.sv
// rule_dispatch: issues a rule lookup per descriptor, pairs in-order rule returns with
// their metadata and decodes the forwarding action. Optional counters: RULE_DISPATCH_STAT_EN.
module rule_dispatch #(
    parameter int DEPTH      = 8,
    parameter int THREAD_NUM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [15:0] desc_index,
    input  logic [31:0] desc_md,
    output logic        lookup2rule_index_wr,
    output logic [15:0] lookup2rule_index,
    input  logic        rule2lookup_data_wr,
    input  logic [31:0] rule2lookup_data,
    output logic        act_valid,
    input  logic        act_ready,
    output logic        act_discard,
    output logic        act_to_cpu,
    output logic [7:0]  act_port_id,
    output logic [31:0] act_md,
    output logic        err_rule_ovf,
    output logic [31:0] stat_discard_cnt,
    output logic [31:0] stat_fwd_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [7:0]    POLL_LAST = 8'(THREAD_NUM - 1);

    // Returns {discard, to_cpu, port}
    function automatic logic [9:0] decode_rule(input logic [3:0] ctrl, input logic [7:0] p,
                                               input logic [7:0] poll);
        case (ctrl)
            4'd1:    decode_rule = {1'b0, 1'b1, p};
            4'd2:    decode_rule = {1'b0, 1'b1, poll};
            4'd3:    decode_rule = {1'b0, 1'b0, p};
            default: decode_rule = {1'b1, 1'b0, 8'd0};
        endcase
    endfunction

    logic [31:0]   meta_mem_q [DEPTH];
    logic [11:0]   rule_mem_q [DEPTH];   // only ctrl and p are ever used downstream
    logic [AW-1:0] meta_wp_q, meta_wp_d, meta_rp_q, meta_rp_d;
    logic [AW-1:0] rule_wp_q, rule_wp_d, rule_rp_q, rule_rp_d;
    logic [CW-1:0] rule_cnt_q, rule_cnt_d, pend_q, pend_d, out_cnt_q, out_cnt_d;
    logic [7:0]    poll_q, poll_d;
    logic          err_q, err_d, wr_q, wr_d;
    logic [15:0]   idx_q, idx_d;
    logic          valid_q, valid_d, discard_q, discard_d, to_cpu_q, to_cpu_d;
    logic [7:0]    port_q, port_d;
    logic [31:0]   md_q, md_d;
    logic          accept_s, rule_push_s, load_s, hs_s;
    logic [11:0]   rule_head_s;
    logic          dec_discard_s, dec_to_cpu_s;
    logic [7:0]    dec_port_s;
    logic          unused_rule_s;

    assign unused_rule_s = ^rule2lookup_data[27:8];
    assign desc_ready    = ~rst & (out_cnt_q < DEPTH_C);
    assign accept_s      = desc_valid & desc_ready;
    assign hs_s          = valid_q & act_ready;
    // pend_q counts requests still waiting for their rule; a return with none is stray
    assign rule_push_s   = rule2lookup_data_wr & (pend_q != {CW{1'b0}});
    assign load_s        = (rule_cnt_q != {CW{1'b0}}) & (~valid_q | act_ready);
    assign rule_head_s   = rule_mem_q[rule_rp_q];
    assign {dec_discard_s, dec_to_cpu_s, dec_port_s} =
        decode_rule(rule_head_s[11:8], rule_head_s[7:0], poll_q);

    // Next-state for pointers, counters, lookup strobe and output register
    always_comb begin
        meta_wp_d  = accept_s    ? meta_wp_q + AW'(1'b1) : meta_wp_q;
        meta_rp_d  = load_s      ? meta_rp_q + AW'(1'b1) : meta_rp_q;
        rule_wp_d  = rule_push_s ? rule_wp_q + AW'(1'b1) : rule_wp_q;
        rule_rp_d  = load_s      ? rule_rp_q + AW'(1'b1) : rule_rp_q;
        rule_cnt_d = rule_cnt_q + CW'(rule_push_s) - CW'(load_s);
        pend_d     = pend_q + CW'(accept_s) - CW'(rule_push_s);
        out_cnt_d  = out_cnt_q + CW'(accept_s) - CW'(hs_s);
        err_d      = err_q | (rule2lookup_data_wr & ~rule_push_s);
        wr_d       = accept_s;
        idx_d      = accept_s ? desc_index : idx_q;
        poll_d     = poll_q;
        valid_d    = valid_q;
        discard_d  = discard_q;
        to_cpu_d   = to_cpu_q;
        port_d     = port_q;
        md_d       = md_q;
        if (load_s) begin
            valid_d   = 1'b1;
            discard_d = dec_discard_s;
            to_cpu_d  = dec_to_cpu_s;
            port_d    = dec_port_s;
            md_d      = meta_mem_q[meta_rp_q];
            if (rule_head_s[11:8] == 4'd2) begin
                poll_d = (poll_q == POLL_LAST) ? 8'd0 : poll_q + 8'd1;
            end else begin
                poll_d = poll_q;
            end
        end else if (hs_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers and FIFO storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                meta_mem_q[i] <= 32'd0;
                rule_mem_q[i] <= 12'd0;
            end
            meta_wp_q  <= {AW{1'b0}};
            meta_rp_q  <= {AW{1'b0}};
            rule_wp_q  <= {AW{1'b0}};
            rule_rp_q  <= {AW{1'b0}};
            rule_cnt_q <= {CW{1'b0}};
            pend_q     <= {CW{1'b0}};
            out_cnt_q  <= {CW{1'b0}};
            poll_q     <= 8'd0;
            err_q      <= 1'b0;
            wr_q       <= 1'b0;
            idx_q      <= 16'd0;
            valid_q    <= 1'b0;
            discard_q  <= 1'b0;
            to_cpu_q   <= 1'b0;
            port_q     <= 8'd0;
            md_q       <= 32'd0;
        end else begin
            if (accept_s) meta_mem_q[meta_wp_q] <= desc_md;
            if (rule_push_s) rule_mem_q[rule_wp_q] <= {rule2lookup_data[31:28], rule2lookup_data[7:0]};
            meta_wp_q  <= meta_wp_d;
            meta_rp_q  <= meta_rp_d;
            rule_wp_q  <= rule_wp_d;
            rule_rp_q  <= rule_rp_d;
            rule_cnt_q <= rule_cnt_d;
            pend_q     <= pend_d;
            out_cnt_q  <= out_cnt_d;
            poll_q     <= poll_d;
            err_q      <= err_d;
            wr_q       <= wr_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            discard_q  <= discard_d;
            to_cpu_q   <= to_cpu_d;
            port_q     <= port_d;
            md_q       <= md_d;
        end
    end

    assign lookup2rule_index_wr = wr_q;
    assign lookup2rule_index    = idx_q;
    assign act_valid            = valid_q;
    assign act_discard          = discard_q;
    assign act_to_cpu           = to_cpu_q;
    assign act_port_id          = port_q;
    assign act_md               = md_q;
    assign err_rule_ovf         = err_q;

`ifdef RULE_DISPATCH_STAT_EN
    logic [31:0] disc_cnt_q, disc_cnt_d, fwd_cnt_q, fwd_cnt_d;

    // Saturating result counters, stepped on each handshake
    always_comb begin
        disc_cnt_d = disc_cnt_q;
        fwd_cnt_d  = fwd_cnt_q;
        if (hs_s && discard_q && (disc_cnt_q != 32'hFFFF_FFFF)) begin
            disc_cnt_d = disc_cnt_q + 32'd1;
        end else if (hs_s && !discard_q && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end else begin
            disc_cnt_d = disc_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disc_cnt_q <= 32'd0;
            fwd_cnt_q  <= 32'd0;
        end else begin
            disc_cnt_q <= disc_cnt_d;
            fwd_cnt_q  <= fwd_cnt_d;
        end
    end

    assign stat_discard_cnt = disc_cnt_q;
    assign stat_fwd_cnt     = fwd_cnt_q;
`else
    assign stat_discard_cnt = 32'd0;
    assign stat_fwd_cnt     = 32'd0;
`endif
endmodule

// File: tb/tb_rule_dispatch.sv
// Directed bench for rule_dispatch: a scoreboard of expected results filled as rules are returned.
module tb_rule_dispatch;
    localparam int DEPTH      = 8;
    localparam int THREAD_NUM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [15:0] desc_index = 16'd0;
    logic [31:0] desc_md = 32'd0;
    logic        lookup2rule_index_wr;
    logic [15:0] lookup2rule_index;
    logic        rule2lookup_data_wr = 1'b0;
    logic [31:0] rule2lookup_data = 32'd0;
    logic        act_valid;
    logic        act_ready = 1'b1;
    logic        act_discard;
    logic        act_to_cpu;
    logic [7:0]  act_port_id;
    logic [31:0] act_md;
    logic        err_rule_ovf;
    logic [31:0] stat_discard_cnt;
    logic [31:0] stat_fwd_cnt;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    logic [31:0] md_m [$];
    logic [41:0] exp_q [$];   // {discard, to_cpu, port, md}
    logic [7:0]  poll_m = 8'd0;
    logic        stall_seen = 1'b0;
    logic [41:0] stall_val;
    logic [41:0] mon_exp;

    always #5 clk = ~clk;

    rule_dispatch #(.DEPTH(DEPTH), .THREAD_NUM(THREAD_NUM)) dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_index(desc_index), .desc_md(desc_md),
        .lookup2rule_index_wr(lookup2rule_index_wr), .lookup2rule_index(lookup2rule_index),
        .rule2lookup_data_wr(rule2lookup_data_wr), .rule2lookup_data(rule2lookup_data),
        .act_valid(act_valid), .act_ready(act_ready),
        .act_discard(act_discard), .act_to_cpu(act_to_cpu),
        .act_port_id(act_port_id), .act_md(act_md),
        .err_rule_ovf(err_rule_ovf),
        .stat_discard_cnt(stat_discard_cnt), .stat_fwd_cnt(stat_fwd_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count lookup strobes
    always @(negedge clk) begin
        if (!rst && lookup2rule_index_wr) wr_cnt <= wr_cnt + 1;
    end

    // Output monitor: stability under stall and in-order scoreboard compare on handshake
    always @(negedge clk) begin
        if (!rst && act_valid) begin
            if (stall_seen) chk("hold_stable", {act_discard, act_to_cpu, act_port_id, act_md}, stall_val);
            if (act_ready) begin
                stall_seen = 1'b0;
                chk("result_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("result", {act_discard, act_to_cpu, act_port_id, act_md}, mon_exp);
                end
            end else begin
                stall_seen = 1'b1;
                stall_val  = {act_discard, act_to_cpu, act_port_id, act_md};
            end
        end else begin
            stall_seen = 1'b0;
        end
    end

    // Drive one descriptor; starts and ends just after a rising edge
    task automatic send(input logic [15:0] idx, input logic [31:0] md);
        int n;
        n = 0;
        desc_valid = 1'b1;
        desc_index = idx;
        desc_md    = md;
        @(negedge clk);
        while (!desc_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("desc_accept", n < 100, 1'b1);
        if (n < 100) begin
            @(posedge clk); #1;
            md_m.push_back(md);
        end
        desc_valid = 1'b0;
    endtask

    // Return one rule; the expectation comes from the metadata of the oldest open request
    task automatic ret(input logic [31:0] rule);
        logic [31:0] md;
        logic [3:0]  ctrl;
        rule2lookup_data_wr = 1'b1;
        rule2lookup_data    = rule;
        ctrl = rule[31:28];
        if (md_m.size() != 0) begin
            md = md_m.pop_front();
            if (ctrl == 4'd1) begin
                exp_q.push_back({1'b0, 1'b1, rule[7:0], md});
            end else if (ctrl == 4'd2) begin
                exp_q.push_back({1'b0, 1'b1, poll_m, md});
                poll_m = (poll_m == 8'(THREAD_NUM - 1)) ? 8'd0 : poll_m + 8'd1;
            end else if (ctrl == 4'd3) begin
                exp_q.push_back({1'b0, 1'b0, rule[7:0], md});
            end else begin
                exp_q.push_back({1'b1, 1'b0, 8'd0, md});
            end
        end
        @(posedge clk); #1;
        rule2lookup_data_wr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || act_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", n < 300, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        desc_valid = 1'b0;
        rule2lookup_data_wr = 1'b0;
        md_m.delete();
        exp_q.delete();
        poll_m = 8'd0;
        @(negedge clk);
        chk("rst_desc_ready", desc_ready, 1'b0);
        chk("rst_outputs", {act_valid, act_discard, act_to_cpu, act_port_id, act_md,
                            lookup2rule_index_wr, err_rule_ovf}, 64'd0);
        chk("rst_stats", {stat_discard_cnt, stat_fwd_cnt}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("desc_ready_release", desc_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        int w0;
        #2;
        do_reset();

        // Port forwarding with latency check
        send(16'h0005, 32'hA5A5_0001);
        @(negedge clk);
        chk("l2r_wr", lookup2rule_index_wr, 1'b1);
        chk("l2r_index", lookup2rule_index, 16'h0005);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l2r_wr_one_cycle", lookup2rule_index_wr, 1'b0);
        @(posedge clk); #1;
        ret(32'h3000_0007);
        @(negedge clk);
        chk("act_latency", act_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fwd_fields", {act_valid, act_discard, act_to_cpu, act_port_id, act_md},
            {1'b1, 1'b0, 1'b0, 8'h07, 32'hA5A5_0001});
        @(posedge clk); #1;
        drain();

        // Polling thread rotation: 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) send(16'h0010 + 16'(i), 32'hB000_0000 + 32'(i));
        for (int i = 0; i < 6; i++) ret(32'h2000_0000);
        drain();

        // Decode: ctrl 0, ctrl 1 port 9, ctrl 15
        send(16'h0020, 32'hC000_0000);
        send(16'h0021, 32'hC000_0001);
        send(16'h0022, 32'hC000_0002);
        ret(32'h0000_0003);
        ret(32'h1000_0009);
        ret(32'hF000_0002);
        drain();

        // Backpressure: 8 outstanding fills the window
        act_ready = 1'b0;
        @(negedge clk);
        w0 = wr_cnt;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(16'h0030 + 16'(i), 32'hD000_0000 + 32'(i));
        @(negedge clk);
        chk("bp_desc_ready_low", desc_ready, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) ret(32'h3000_0040 + 32'(i));
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("bp_wr_count", wr_cnt - w0, 8);
        chk("bp_still_full", desc_ready, 1'b0);
        @(posedge clk); #1;
        act_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_throughput", act_valid, 1'b1);
        end
        @(posedge clk); #1;
        drain();
        @(negedge clk);
        chk("bp_desc_ready_high", desc_ready, 1'b1);
        @(posedge clk); #1;

        // Irregular act_ready pattern
        for (int i = 0; i < 6; i++) begin
            send(16'h0050 + 16'(i), 32'hE000_0000 + 32'(i));
            ret({4'(i), 20'd0, 8'h60 + 8'(i)});
            act_ready = 1'($urandom_range(0, 1));
        end
        act_ready = 1'b1;
        drain();

        // Counters from a clean reset: 3 discards, 5 forwards
        do_reset();
        for (int i = 0; i < 8; i++) send(16'h0070 + 16'(i), 32'hF000_0000 + 32'(i));
        ret(32'h0000_0001);
        ret(32'h3000_0002);
        ret(32'h1000_0003);
        ret(32'h5000_0004);
        ret(32'h2000_0005);
        ret(32'h3000_0006);
        ret(32'hF000_0007);
        ret(32'h1000_0008);
        drain();
`ifdef RULE_DISPATCH_STAT_EN
        chk("stat_discard", stat_discard_cnt, 32'd3);
        chk("stat_fwd", stat_fwd_cnt, 32'd5);
`else
        chk("stat_discard_off", stat_discard_cnt, 32'd0);
        chk("stat_fwd_off", stat_fwd_cnt, 32'd0);
`endif

        // Stray return sets the sticky error
        @(negedge clk);
        chk("err_clear", err_rule_ovf, 1'b0);
        @(posedge clk); #1;
        ret(32'h3000_0001);
        @(negedge clk);
        chk("err_set", err_rule_ovf, 1'b1);
        @(posedge clk); #1;

        // Reset mid-stream with 3 outstanding, then a late return for a pre-reset request
        send(16'h0080, 32'h1111_0000);
        send(16'h0081, 32'h1111_0001);
        send(16'h0082, 32'h1111_0002);
        ret(32'h3000_0003);
        do_reset();
        ret(32'h3000_0004);
        @(negedge clk);
        chk("err_after_reset", err_rule_ovf, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("no_result_after_reset", act_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
